// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage MIPS core.
// Holds the PC, chooses the next PC from decode-stage redirect info
// (single delay slot, nothing squashed here), screens illegal fetches
// into nops and keeps saturating stall/fetch statistics.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic [1:0]  NPCsel_D,
  input  logic        cmp_D,
  input  logic [31:0] RS_D,
  input  logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        pc_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);

  logic        [31:0] pc4_d;
  logic signed [31:0] br_off;
  logic        [31:0] npc;
  logic               fetch_ok;

  // Saturating increment for the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc4_d  = PC_D + 32'd4;
  assign PC8_D  = PC_D + 32'd8;
  assign br_off = {{14{IR_D[15]}}, IR_D[15:0], 2'b00};

  // The range test uses the offset from PC_RESET so one unsigned compare
  // rejects addresses both below and above the instruction memory.
  assign fetch_ok = (PC_F[1:0] == 2'b00) && ((PC_F - PC_RESET) < IM_BYTES);

  // Next-PC select from the instruction currently in D.
  always_comb begin
    npc = PC_F + 32'd4;
    case (NPCsel_D)
      2'b01:   if (cmp_D) npc = pc4_d + $unsigned(br_off);
      2'b10:   npc = RS_D;
      2'b11:   npc = {pc4_d[31:28], IR_D[25:0], 2'b00};
      default: npc = PC_F + 32'd4;
    endcase
  end

  // F -> D boundary: PC advance, IF/ID capture, error flag and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_F      <= PC_RESET;
      IR_D      <= 32'h0;
      PC_D      <= PC_RESET;
      pc_err    <= 1'b0;
      stall_cnt <= 32'h0;
      fetch_cnt <= 32'h0;
    end else if (pause) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else begin
      PC_F      <= npc;
      PC_D      <= PC_F;
      IR_D      <= fetch_ok ? instr_F : 32'h0;
      if (!fetch_ok) pc_err <= 1'b1;
      fetch_cnt <= sat_inc(fetch_cnt);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: each stimulus step pushes the
// hand-computed post-edge state; a monitor pops and compares every cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  NPCsel_D = 2'b00;
  logic        cmp_D = 1'b0;
  logic [31:0] RS_D = 32'h0;
  logic [31:0] instr_F = 32'h0;
  logic [31:0] PC_F, IR_D, PC_D, PC8_D, stall_cnt, fetch_cnt;
  logic        pc_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [31:0] pcf;
    logic [31:0] ir;
    logic [31:0] pcd;
    logic [31:0] pc8;
    logic        err;
    logic [31:0] st;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];

  fetch_stage #(.PC_RESET(32'h0000_3000), .IM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .pause(pause), .NPCsel_D(NPCsel_D),
    .cmp_D(cmp_D), .RS_D(RS_D), .instr_F(instr_F), .PC_F(PC_F),
    .IR_D(IR_D), .PC_D(PC_D), .PC8_D(PC8_D), .pc_err(pc_err),
    .stall_cnt(stall_cnt), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input int id, input string f, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d %s got=%h want=%h", id, f, got, want);
    end
  endtask

  // Monitor: state after each stimulus edge is checked on the next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.id, "PC_F", PC_F, e.pcf);
        chk(e.id, "IR_D", IR_D, e.ir);
        chk(e.id, "PC_D", PC_D, e.pcd);
        chk(e.id, "PC8_D", PC8_D, e.pc8);
        chk(e.id, "pc_err", {31'h0, pc_err}, {31'h0, e.err});
        chk(e.id, "stall_cnt", stall_cnt, e.st);
        chk(e.id, "fetch_cnt", fetch_cnt, e.fc);
      end
    end
  end

  int step_no = 0;

  task automatic step(input logic rst, input logic pz, input logic [1:0] sel,
                      input logic c, input logic [31:0] rs, input logic [31:0] ins,
                      input logic [31:0] pcf, input logic [31:0] ir,
                      input logic [31:0] pcd, input logic err,
                      input logic [31:0] st, input logic [31:0] fc);
    exp_t e;
    @(negedge clk);
    #1;
    reset    = rst;
    pause    = pz;
    NPCsel_D = sel;
    cmp_D    = c;
    RS_D     = rs;
    instr_F  = ins;
    e.id  = step_no;
    e.pcf = pcf;
    e.ir  = ir;
    e.pcd = pcd;
    e.pc8 = pcd + 32'd8;
    e.err = err;
    e.st  = st;
    e.fc  = fc;
    sb.push_back(e);
    step_no++;
  endtask

  localparam logic [31:0] BEQ_M2  = 32'h1000_FFFE;  // beq, imm -2
  localparam logic [31:0] JAL_C10 = 32'h0C00_0C10;  // jal, target field 0xC10
  localparam logic [31:0] BEQ_P16 = 32'h1000_0010;  // beq, imm +16

  initial begin
    //    rst pz  sel   c  RS_D          instr_F       PC_F          IR_D          PC_D          err st  fc
    step(1, 0, 2'b00, 0, 32'h0,        32'h0,        32'h3000,     32'h0,        32'h3000,     0, 0, 0);
    // sequential fetch A, B, then the beq as C
    step(0, 0, 2'b00, 0, 32'h0,        32'h1111_1111, 32'h3004,    32'h1111_1111, 32'h3000,    0, 0, 1);
    step(0, 0, 2'b00, 0, 32'h0,        32'h2222_2222, 32'h3008,    32'h2222_2222, 32'h3004,    0, 0, 2);
    step(0, 0, 2'b00, 0, 32'h0,        BEQ_M2,        32'h300C,    BEQ_M2,        32'h3008,    0, 0, 3);
    // taken beq: delay slot at 300C latched, target 300C-8 = 3004
    step(0, 0, 2'b01, 1, 32'h0,        32'h4444_4444, 32'h3004,    32'h4444_4444, 32'h300C,    0, 0, 4);
    step(0, 0, 2'b00, 0, 32'h0,        32'h5555_5555, 32'h3008,    32'h5555_5555, 32'h3004,    0, 0, 5);
    step(0, 0, 2'b00, 0, 32'h0,        32'h6666_6666, 32'h300C,    32'h6666_6666, 32'h3008,    0, 0, 6);
    step(0, 0, 2'b00, 0, 32'h0,        32'h7777_7777, 32'h3010,    32'h7777_7777, 32'h300C,    0, 0, 7);
    // jal in D at 3010 (PC8_D = 3018), then delay slot, then target 3040
    step(0, 0, 2'b00, 0, 32'h0,        JAL_C10,       32'h3014,    JAL_C10,       32'h3010,    0, 0, 8);
    step(0, 0, 2'b11, 0, 32'h0,        32'h8888_8888, 32'h3040,    32'h8888_8888, 32'h3014,    0, 0, 9);
    // jr to 3100
    step(0, 0, 2'b10, 0, 32'h3100,     32'h9999_9999, 32'h3100,    32'h9999_9999, 32'h3040,    0, 0, 10);
    step(0, 0, 2'b00, 0, 32'h0,        BEQ_P16,       32'h3104,    BEQ_P16,       32'h3100,    0, 0, 11);
    // pause three cycles with beq in D and cmp_D toggling: everything frozen
    step(0, 1, 2'b01, 1, 32'h0,        32'hAAAA_AAAA, 32'h3104,    BEQ_P16,       32'h3100,    0, 1, 11);
    step(0, 1, 2'b01, 0, 32'h0,        32'hAAAA_AAAA, 32'h3104,    BEQ_P16,       32'h3100,    0, 2, 11);
    step(0, 1, 2'b01, 1, 32'h0,        32'hAAAA_AAAA, 32'h3104,    BEQ_P16,       32'h3100,    0, 3, 11);
    // first unpaused cycle has cmp_D=0: not taken, sequential
    step(0, 0, 2'b01, 0, 32'h0,        32'hBBBB_BBBB, 32'h3108,    32'hBBBB_BBBB, 32'h3104,    0, 3, 12);
    // jr to misaligned 3102: its fetch becomes a nop and sets pc_err
    step(0, 0, 2'b10, 0, 32'h3102,     32'hCCCC_CCCC, 32'h3102,    32'hCCCC_CCCC, 32'h3108,    0, 3, 13);
    step(0, 0, 2'b00, 0, 32'h0,        32'hDDDD_DDDD, 32'h3106,    32'h0,         32'h3102,    1, 3, 14);
    step(0, 0, 2'b00, 0, 32'h0,        32'hEEEE_EEEE, 32'h310A,    32'h0,         32'h3106,    1, 3, 15);
    // reset while paused mid-branch
    step(1, 1, 2'b01, 1, 32'h0,        32'hEEEE_EEEE, 32'h3000,    32'h0,         32'h3000,    0, 0, 0);
    // last legal word 3FFC, then 4000 is out of range
    step(0, 0, 2'b10, 0, 32'h3FFC,     32'h6060_6060, 32'h3FFC,    32'h6060_6060, 32'h3000,    0, 0, 1);
    step(0, 0, 2'b00, 0, 32'h0,        32'h7070_7070, 32'h4000,    32'h7070_7070, 32'h3FFC,    0, 0, 2);
    // illegal PC while paused: no error yet
    step(0, 1, 2'b00, 0, 32'h0,        32'h8080_8080, 32'h4000,    32'h7070_7070, 32'h3FFC,    0, 1, 2);
    step(0, 0, 2'b00, 0, 32'h0,        32'h9090_9090, 32'h4004,    32'h0,         32'h4000,    1, 1, 3);
    // reset, then jr to 0x7000 beyond the memory
    step(1, 0, 2'b00, 0, 32'h0,        32'h0,         32'h3000,    32'h0,         32'h3000,    0, 0, 0);
    step(0, 0, 2'b10, 0, 32'h7000,     32'hA0A0_A0A0, 32'h7000,    32'hA0A0_A0A0, 32'h3000,    0, 0, 1);
    step(0, 0, 2'b00, 0, 32'h0,        32'hB0B0_B0B0, 32'h7004,    32'h0,         32'h7000,    1, 0, 2);
    step(0, 0, 2'b00, 0, 32'h0,        32'hC0C0_C0C0, 32'h7008,    32'h0,         32'h7004,    1, 0, 3);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
